// File: rtl/mmio_uart_tx_pkg.sv
// Shared register map, STATUS layout and FSM encoding for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  // Write-one-to-clear position of the sticky overflow flag.
  localparam int unsigned ST_OVF = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic [3:0]  count;
    logic [3:0]  rsvd_lo;
    logic        overflow;
    logic        empty;
    logic        full;
    logic        busy;
  } status_t;

  // A zero divisor would stall the baud counter; treat it as one clock per bit.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Byte FIFO feeding the UART serialiser; pointers wrap naturally on a power-of-2 depth.
module mmio_uart_tx_fifo
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout_c,
  output logic              full_c,
  output logic              empty_c,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign dout_c  = mem[rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full_c || pop);
  assign do_pop  = pop && !empty_c;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud/bit counters and frame FSM.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR  = 32'h0000_4000,
  parameter int unsigned      FIFO_DEPTH = 8,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic [3:0]  mask_singal,
  input  logic [31:0] store_data,
  input  logic [31:0] address,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        offset;
  logic              wr_en;
  logic              push_req;
  logic              ovf_clr;
  logic              pop;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic [DIV_W-1:0]  divisor;
  logic [DIV_W-1:0]  load_div;
  tx_state_e         state;
  logic [DATA_W-1:0] shift;
  logic [2:0]        bit_cnt;
  logic [DIV_W-1:0]  baud_cnt;
  logic [DIV_W-1:0]  div_q;
  status_t           status;
  logic              unused_bits;

  assign offset   = address[3:2];
  assign hit      = (address[31:4] == BASE_ADDR[31:4]);
  assign wr_en    = write && hit;
  assign push_req = wr_en && (offset == REG_TXDATA) && mask_singal[0];
  assign ovf_clr  = wr_en && (offset == REG_STATUS) && mask_singal[0] && store_data[ST_OVF];
  assign load_div = clamp_div(divisor);

  // Head leaves the FIFO when a frame starts, either from idle or straight out of a stop bit.
  assign pop = !fifo_empty &&
               ((state == S_IDLE) || ((state == S_STOP) && (baud_cnt == '0)));

  assign irq_empty   = fifo_empty && (state == S_IDLE);
  assign unused_bits = ^{address[1:0], mask_singal[3:2], store_data[31:16]};

  mmio_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .pop     (pop),
    .din     (store_data[DATA_W-1:0]),
    .dout_c  (fifo_dout),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count)
  );

  // Sticky overflow: set when a byte is dropped, cleared by writing 1 to its STATUS bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor <= DIV_RESET;
    end else if (wr_en && (offset == REG_DIVISOR)) begin
      if (mask_singal[0]) divisor[7:0]  <= store_data[7:0];
      if (mask_singal[1]) divisor[15:8] <= store_data[15:8];
    end
  end

  // Frame sequencer; every non-idle state holds for div_q clocks latched at frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      div_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            shift    <= fifo_dout;
            div_q    <= load_div;
            baud_cnt <= load_div - DIV_W'(1);
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= div_q - DIV_W'(1);
            bit_cnt  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= div_q - DIV_W'(1);
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[DATA_W-1:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        S_STOP: begin
          if (baud_cnt == '0) begin
            if (!fifo_empty) begin
              shift    <= fifo_dout;
              div_q    <= load_div;
              baud_cnt <= load_div - DIV_W'(1);
              state    <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - DIV_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line driver trails the sequencer by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx <= 1'b1;
    end else begin
      case (state)
        S_START: tx <= 1'b0;
        S_DATA:  tx <= shift[0];
        default: tx <= 1'b1;
      endcase
    end
  end

  always_comb begin
    status          = '0;
    status.busy     = (state != S_IDLE);
    status.full     = fifo_full;
    status.empty    = fifo_empty;
    status.overflow = overflow;
    status.count    = 4'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (offset)
        REG_STATUS:  rdata = status;
        REG_DIVISOR: rdata = 32'(divisor);
        REG_TXDATA:  rdata = '0;
        REG_RSVD:    rdata = '0;
        default:     rdata = '0;
      endcase
    end
  end

endmodule
